// File: rtl/axi_sram_slave_if.sv
// AXI3 single-beat bus bundle between a CPU master port and axi_sram_slave.
interface axi_sram_slave_if;
    // Read address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    // Read data channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    // Write address channel
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    // Write data channel
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    // Write response channel
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 slave backed by a word-addressed memory array.
// Independent read and write paths, one outstanding transaction each.
// Optional build macro AXI_SLV_RAND_STALL_EN adds LFSR-driven ready and
// read-latency stalls for stress testing the master.
module axi_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
    parameter int          MEM_AW    = 12,
    parameter int          RD_LAT    = 1
) (
    input  logic            aclk,
    input  logic            aresetn,
    axi_sram_slave_if.slave bus
);
    localparam int         DEPTH  = 1 << MEM_AW;
    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    // Word offset from base; anything beyond the array depth is a miss.
    function automatic logic addr_hit(input logic [31:0] a);
        logic [31:0] off;
        off = (a >> 2) - (BASE_ADDR >> 2);
        return (off >> MEM_AW) == 32'd0;
    endfunction

    function automatic logic [MEM_AW-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = (a >> 2) - (BASE_ADDR >> 2);
        return off[MEM_AW-1:0];
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0] mem [DEPTH];

    logic ar_gate, aw_gate, w_gate, lat_gate;

`ifdef AXI_SLV_RAND_STALL_EN
    logic [7:0] lfsr;

    // Free-running x^8+x^6+x^5+x^4+1 LFSR providing pseudo-random stalls
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) lfsr <= 8'h5A;
        else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign ar_gate  = lfsr[0];
    assign aw_gate  = lfsr[1];
    assign w_gate   = lfsr[2];
    assign lat_gate = lfsr[3];
`else
    assign ar_gate  = 1'b1;
    assign aw_gate  = 1'b1;
    assign w_gate   = 1'b1;
    assign lat_gate = 1'b1;
`endif

    // ---------------- read path ----------------
    r_state_t          r_state, r_next;
    logic [3:0]        rd_cnt;
    logic [MEM_AW-1:0] rd_idx;
    logic              rd_err;
    logic [3:0]        r_id;
    logic [31:0]       r_data;
    logic [1:0]        r_resp;
    logic              ar_hs, ar_err, rd_capture;
    logic [MEM_AW-1:0] cap_idx;
    logic              cap_err;
    logic [31:0]       cap_word;

    // ---------------- write path ----------------
    logic              aw_held, w_held;
    logic [MEM_AW-1:0] wr_idx;
    logic              wr_err;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic [3:0]        b_id;
    logic [1:0]        b_resp;
    logic              b_valid;
    logic              aw_hs, w_hs, wr_commit;

    assign bus.arready = (r_state == R_IDLE) && ar_gate;
    assign bus.rvalid  = (r_state == R_RESP);
    assign bus.rid     = r_id;
    assign bus.rdata   = r_data;
    assign bus.rresp   = r_resp;
    assign bus.rlast   = 1'b1;

    assign ar_hs  = bus.arvalid && bus.arready;
    assign ar_err = !addr_hit(bus.araddr) || (bus.arlen != 8'd0);

    // Read FSM next state; a one-cycle latency captures straight from idle
    always_comb begin
        r_next     = r_state;
        rd_capture = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    if ((LAT_M1 == 4'd0) && lat_gate) begin
                        rd_capture = 1'b1;
                        r_next     = R_RESP;
                    end else begin
                        r_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if ((rd_cnt <= 4'd1) && lat_gate) begin
                    rd_capture = 1'b1;
                    r_next     = R_RESP;
                end
            end
            R_RESP: begin
                if (bus.rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Capture word, forwarding a same-cycle write so reads see write-first data
    always_comb begin
        cap_idx  = (r_state == R_IDLE) ? addr_idx(bus.araddr) : rd_idx;
        cap_err  = (r_state == R_IDLE) ? ar_err : rd_err;
        cap_word = mem[cap_idx];
        if (wr_commit && !wr_err && (wr_idx == cap_idx))
            cap_word = merge_bytes(cap_word, wr_data, wr_strb);
    end

    // Read request latch, latency counter and response registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_cnt <= 4'd0;
            rd_idx <= '0;
            rd_err <= 1'b0;
            r_id   <= 4'd0;
            r_data <= 32'd0;
            r_resp <= OKAY;
        end else begin
            if (ar_hs) begin
                rd_cnt <= LAT_M1;
                rd_idx <= addr_idx(bus.araddr);
                rd_err <= ar_err;
                r_id   <= bus.arid;
            end else if ((r_state == R_WAIT) && (rd_cnt != 4'd0)) begin
                rd_cnt <= rd_cnt - 4'd1;
            end
            if (rd_capture) begin
                r_data <= cap_err ? 32'd0 : cap_word;
                r_resp <= cap_err ? SLVERR : OKAY;
            end
        end
    end

    assign bus.awready = !aw_held && !b_valid && aw_gate;
    assign bus.wready  = !w_held && !b_valid && w_gate;
    assign bus.bid     = b_id;
    assign bus.bresp   = b_resp;
    assign bus.bvalid  = b_valid;

    assign aw_hs     = bus.awvalid && bus.awready;
    assign w_hs      = bus.wvalid && bus.wready;
    assign wr_commit = aw_held && w_held;

    // Collect AW and W in any order, commit once both are held, then respond
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            wr_idx  <= '0;
            wr_err  <= 1'b0;
            wr_data <= 32'd0;
            wr_strb <= 4'd0;
            b_id    <= 4'd0;
            b_resp  <= OKAY;
            b_valid <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                wr_idx  <= addr_idx(bus.awaddr);
                wr_err  <= !addr_hit(bus.awaddr) || (bus.awlen != 8'd0);
                b_id    <= bus.awid;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wr_data <= bus.wdata;
                wr_strb <= bus.wstrb;
            end
            if (wr_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                b_valid <= 1'b1;
                b_resp  <= wr_err ? SLVERR : OKAY;
            end else if (b_valid && bus.bready) begin
                b_valid <= 1'b0;
            end
        end
    end

    // Memory array write port; contents are not cleared by reset
    always_ff @(posedge aclk) begin
        if (wr_commit && !wr_err)
            mem[wr_idx] <= merge_bytes(mem[wr_idx], wr_data, wr_strb);
    end
endmodule
